// File: rtl/encrypt_iterative_if.sv
// encrypt_iterative_if: request/result bundle for the iterative AES core.
// master drives start/in/key; slave returns out/done.
interface encrypt_iterative_if #(
    parameter int KEY_WIDTH = 128
) ();
    logic                 start;
    logic [127:0]         in;
    logic [KEY_WIDTH-1:0] key;
    logic [127:0]         out;
    logic                 done;

    modport master (output start, in, key, input out, done);
    modport slave (input start, in, key, output out, done);
endinterface

// File: rtl/encrypt_iterative.sv
// encrypt_iterative: AES-128/192/256 encryptor, one round per clock.
// Ports: clk, rst (async, active-low), bus (slave: start/in/key -> out/done).
// Optional macro ENCRYPT_ITERATIVE_PARAM_CHECK_EN: time-0 check of (KEY_WIDTH,NR,NK).
module encrypt_iterative #(
    parameter int KEY_WIDTH = 128,
    parameter int NR        = 10,
    parameter int NK        = 4
) (
    input logic                clk,
    input logic                rst,
    encrypt_iterative_if.slave bus
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINISH} fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] state;
    logic [31:0]  win [8];
    logic [127:0] out_q;
    logic         done_q;

    logic [31:0]  nxt [8];
    logic [127:0] rk;
    logic [127:0] rnd;

    assign bus.out  = out_q;
    assign bus.done = done_q;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input int n);
        case (n)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // win holds w[4(r-1) .. 4(r-1)+NK-1] during round r; nxt slides it
    // by four words, so nxt[0..3] is exactly the round-r key.
    always_comb begin
        logic [31:0] t;
        int          i;
        for (int j = 0; j < 8; j++) nxt[j] = '0;
        for (int j = 0; j < NK - 4; j++) nxt[j] = win[j+4];
        t = win[NK-1];
        for (int k = 0; k < 4; k++) begin
            i = 4 * (int'(round) - 1) + NK + k;
            if (i % NK == 0)
                t = subword({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h0};
            else if (NK == 8 && i % NK == 4)
                t = subword(t);
            t = win[k] ^ t;
            nxt[NK-4+k] = t;
        end
        rk = {nxt[0], nxt[1], nxt[2], nxt[3]};
    end

    // One full round on the registered state; byte b sits at
    // row b%4, column b/4.
    always_comb begin
        logic [7:0] s [16];
        logic [7:0] r [16];
        logic [7:0] m [16];
        rnd = '0;
        for (int b = 0; b < 16; b++)
            s[b] = sb(state[127-8*b -: 8]);
        for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
                r[4*c+q] = s[4*((c+q)%4)+q];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(r[4*c]) ^ xt(r[4*c+1]) ^ r[4*c+1]
                     ^ r[4*c+2] ^ r[4*c+3];
            m[4*c+1] = r[4*c] ^ xt(r[4*c+1]) ^ xt(r[4*c+2])
                     ^ r[4*c+2] ^ r[4*c+3];
            m[4*c+2] = r[4*c] ^ r[4*c+1] ^ xt(r[4*c+2])
                     ^ xt(r[4*c+3]) ^ r[4*c+3];
            m[4*c+3] = xt(r[4*c]) ^ r[4*c] ^ r[4*c+1]
                     ^ r[4*c+2] ^ xt(r[4*c+3]);
        end
        for (int b = 0; b < 16; b++)
            rnd[127-8*b -: 8] = ((round == 4'(NR)) ? r[b] : m[b])
                              ^ rk[127-8*b -: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm    <= IDLE;
            round  <= '0;
            state  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
            for (int j = 0; j < 8; j++) win[j] <= '0;
        end else if (!bus.start) begin
            // abandon or close the request; out keeps its last value
            fsm    <= IDLE;
            round  <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    state <= bus.in ^ bus.key[KEY_WIDTH-1 -: 128];
                    for (int j = 0; j < NK; j++)
                        win[j] <= bus.key[KEY_WIDTH-1-32*j -: 32];
                    round <= 4'd1;
                    fsm   <= ROUND;
                end
                ROUND: begin
                    state <= rnd;
                    for (int j = 0; j < 8; j++) win[j] <= nxt[j];
                    if (round == 4'(NR)) begin
                        out_q  <= rnd;
                        done_q <= 1'b1;
                        fsm    <= FINISH;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                FINISH: begin
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef ENCRYPT_ITERATIVE_PARAM_CHECK_EN
    initial begin
        if (!((KEY_WIDTH == 128 && NR == 10 && NK == 4) ||
              (KEY_WIDTH == 192 && NR == 12 && NK == 6) ||
              (KEY_WIDTH == 256 && NR == 14 && NK == 8))) begin
            $error("%m: illegal KEY_WIDTH/NR/NK = %0d/%0d/%0d",
                   KEY_WIDTH, NR, NK);
            $fatal(1, "%m: unsupported AES configuration");
        end
    end
`endif
endmodule

// File: tb/tb_encrypt_iterative.sv
// tb_encrypt_iterative: AES-128/192/256 instances on shared clk/rst/start,
// checked against known answers and an algebraic AES model.
module tb_encrypt_iterative;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] pin;
    logic [255:0] pkey;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    encrypt_iterative_if #(.KEY_WIDTH(128)) if128 ();
    encrypt_iterative_if #(.KEY_WIDTH(192)) if192 ();
    encrypt_iterative_if #(.KEY_WIDTH(256)) if256 ();

    assign if128.start = start;
    assign if192.start = start;
    assign if256.start = start;
    assign if128.in    = pin;
    assign if192.in    = pin;
    assign if256.in    = pin;
    assign if128.key   = pkey[255:128];
    assign if192.key   = pkey[255:64];
    assign if256.key   = pkey;

    encrypt_iterative #(.KEY_WIDTH(128), .NR(10), .NK(4))
        u128 (.clk(clk), .rst(rst), .bus(if128));
    encrypt_iterative #(.KEY_WIDTH(192), .NR(12), .NK(6))
        u192 (.clk(clk), .rst(rst), .bus(if192));
    encrypt_iterative #(.KEY_WIDTH(256), .NR(14), .NK(8))
        u256 (.clk(clk), .rst(rst), .bus(if256));

    logic [127:0] outs  [3];
    logic         dones [3];
    assign outs[0]  = if128.out;
    assign outs[1]  = if192.out;
    assign outs[2]  = if256.out;
    assign dones[0] = if128.done;
    assign dones[1] = if192.done;
    assign dones[2] = if256.done;

    logic [7:0]   sbox_t [256];
    int           rise_at [3];
    logic [127:0] last_exp [3];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                      ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]],
                sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt,
                                               input logic [255:0] k,
                                               input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rd < nr) begin
                    s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03)
                            ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02)
                            ^ gmul(t[2][c], 8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02)
                            ^ gmul(t[3][c], 8'h03);
                    s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c]
                            ^ gmul(t[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++)
                    s[r][c] ^= w[4*rd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Records, per instance, the edge (relative to E0) at which done is
    // first seen high. start must have just been raised at a negedge.
    task automatic measure();
        for (int n = 0; n < 3; n++) rise_at[n] = -1;
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++)
                if (dones[n] === 1'b1 && rise_at[n] < 0) rise_at[n] = m - 1;
        end
    endtask

    task automatic idle();
        start = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        pin   = '0;
        pkey  = '0;
        @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (outs[n] !== 128'h0) begin
                n_bad++;
                $display("FAIL reset_out inst%0d got %h want 0", n, outs[n]);
            end
            n_cmp++;
            if (dones[n] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_done inst%0d got %b want 0", n, dones[n]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_kat();
        logic [127:0] kat [3];
        kat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        pin   = 128'h00112233445566778899aabbccddeeff;
        pkey  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        start = 1'b1;
        measure();
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (rise_at[n] !== 10 + 2 * n) begin
                n_bad++;
                $display("FAIL kat_latency inst%0d got %0d want %0d",
                         n, rise_at[n], 10 + 2 * n);
            end
            n_cmp++;
            if (outs[n] !== kat[n]) begin
                n_bad++;
                $display("FAIL kat_out inst%0d got %h want %h", n, outs[n], kat[n]);
            end
            n_cmp++;
            if (dones[n] !== 1'b1) begin
                n_bad++;
                $display("FAIL kat_done_hold inst%0d got %b want 1", n, dones[n]);
            end
            last_exp[n] = kat[n];
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (dones[n] !== 1'b0) begin
                n_bad++;
                $display("FAIL done_fall inst%0d got %b want 0", n, dones[n]);
            end
            n_cmp++;
            if (outs[n] !== last_exp[n]) begin
                n_bad++;
                $display("FAIL out_hold inst%0d got %h want %h",
                         n, outs[n], last_exp[n]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fips128();
        logic [127:0] want;
        pin   = 128'h3243f6a8885a308d313198a2e0370734;
        pkey  = {128'h2b7e151628aed2a6abf7158809cf4f3c, rnd128()};
        start = 1'b1;
        measure();
        n_cmp++;
        if (outs[0] !== 128'h3925841d02dc09fbdc118597196a0b32) begin
            n_bad++;
            $display("FAIL fips128_out got %h want 3925841d02dc09fbdc118597196a0b32",
                     outs[0]);
        end
        for (int n = 0; n < 3; n++) begin
            want = aes_model(pin, pkey, 4 + 2 * n);
            n_cmp++;
            if (outs[n] !== want) begin
                n_bad++;
                $display("FAIL fips_model inst%0d got %h want %h", n, outs[n], want);
            end
            last_exp[n] = want;
        end
        idle();
    endtask

    task automatic test_random();
        logic [127:0] want;
        for (int it = 0; it < 4; it++) begin
            pin   = rnd128();
            pkey  = {rnd128(), rnd128()};
            start = 1'b1;
            measure();
            for (int n = 0; n < 3; n++) begin
                want = aes_model(pin, pkey, 4 + 2 * n);
                n_cmp++;
                if (rise_at[n] !== 10 + 2 * n) begin
                    n_bad++;
                    $display("FAIL rand_latency it%0d inst%0d got %0d want %0d",
                             it, n, rise_at[n], 10 + 2 * n);
                end
                n_cmp++;
                if (outs[n] !== want) begin
                    n_bad++;
                    $display("FAIL rand_out it%0d inst%0d got %h want %h",
                             it, n, outs[n], want);
                end
                last_exp[n] = want;
            end
            idle();
        end
    endtask

    task automatic test_abort();
        logic [127:0] want;
        pin   = rnd128();
        pkey  = {rnd128(), rnd128()};
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                n_cmp++;
                if (dones[n] !== 1'b0 || outs[n] !== last_exp[n]) begin
                    n_bad++;
                    $display("FAIL abort_quiet inst%0d done %b out %h want 0 %h",
                             n, dones[n], outs[n], last_exp[n]);
                end
            end
        end
        pin   = rnd128();
        pkey  = {rnd128(), rnd128()};
        start = 1'b1;
        measure();
        for (int n = 0; n < 3; n++) begin
            want = aes_model(pin, pkey, 4 + 2 * n);
            n_cmp++;
            if (rise_at[n] !== 10 + 2 * n || outs[n] !== want) begin
                n_bad++;
                $display("FAIL abort_retry inst%0d edge %0d out %h want %0d %h",
                         n, rise_at[n], outs[n], 10 + 2 * n, want);
            end
            last_exp[n] = want;
        end
        idle();
    endtask

    task automatic test_rst_mid();
        logic [127:0] want;
        pin   = rnd128();
        pkey  = {rnd128(), rnd128()};
        start = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (outs[n] !== 128'h0 || dones[n] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid inst%0d out %h done %b want 0 0",
                         n, outs[n], dones[n]);
            end
        end
        @(negedge clk);
        pin  = rnd128();
        pkey = {rnd128(), rnd128()};
        rst  = 1'b1;
        measure();
        for (int n = 0; n < 3; n++) begin
            want = aes_model(pin, pkey, 4 + 2 * n);
            n_cmp++;
            if (rise_at[n] !== 10 + 2 * n || outs[n] !== want) begin
                n_bad++;
                $display("FAIL rst_retry inst%0d edge %0d out %h want %0d %h",
                         n, rise_at[n], outs[n], 10 + 2 * n, want);
            end
            last_exp[n] = want;
        end
        idle();
    endtask

    task automatic test_input_change();
        logic [127:0] a_in;
        logic [255:0] a_key;
        logic [127:0] want;
        a_in  = rnd128();
        a_key = {rnd128(), rnd128()};
        pin   = a_in;
        pkey  = a_key;
        start = 1'b1;
        for (int m = 0; m < 19; m++) begin
            @(negedge clk);
            pin  = rnd128();
            pkey = {rnd128(), rnd128()};
        end
        for (int n = 0; n < 3; n++) begin
            want = aes_model(a_in, a_key, 4 + 2 * n);
            n_cmp++;
            if (dones[n] !== 1'b1 || outs[n] !== want) begin
                n_bad++;
                $display("FAIL sampled_inputs inst%0d done %b out %h want 1 %h",
                         n, dones[n], outs[n], want);
            end
            last_exp[n] = want;
        end
        idle();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_kat();
        test_fips128();
        test_random();
        test_abort();
        test_rst_mid();
        test_input_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/encrypt_iterative.md
# encrypt_iterative

AES encryption core (FIPS-197) that processes one 128-bit block per operation, one cipher round per clock, with on-the-fly key expansion. A single parameterised design covers AES-128, AES-192 and AES-256. It sits between a block-level controller, which holds `start` for the whole operation, and downstream logic that samples `out` while `done` is high.

## Interface
- KEY_WIDTH, 128: cipher key width in bits; 128, 192 or 256.
- NR, 10: number of rounds; 10, 12 or 14.
- NK, 4: key length in 32-bit words; 4, 6 or 8.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request; held high for the whole operation.
- in  in  128  plaintext, FIPS-197 byte order (bits [127:120] = byte 0).
- key  in  KEY_WIDTH  cipher key, bits [KEY_WIDTH-1:KEY_WIDTH-8] = key byte 0.
- out  out  128  ciphertext, same byte order as `in`.
- done  out  1  high while `out` holds a valid result for the current request.

## Operation
- FSM states: IDLE, ROUND, FINISH. A round counter runs 1..NR.
- IDLE with start=1 at an edge:
  - state <= in ^ w[0..3], where w[0..3] is the first 128 bits of `key`.
  - Key window <= key words.
  - round <= 1; go to ROUND.
- `in` and `key` are sampled only at this edge. Later changes are ignored until the next request.
- ROUND, round r:
  - Apply SubBytes, ShiftRows, MixColumns (MixColumns skipped when r = NR), then AddRoundKey with w[4r..4r+3].
  - If r = NR: out <= result, done <= 1, go to FINISH. Otherwise r <= r+1.
- Key expansion:
  - An 8-word window register produces 4 new words per cycle combinationally, chained.
  - For each new word: w[i] = w[i-NK] ^ temp, with temp = w[i-1].
  - If i mod NK = 0: temp = SubWord(RotWord(temp)) ^ Rcon[i/NK].
  - If NK = 8 and i mod 8 = 4: temp = SubWord(temp).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- FINISH: `out` and `done` hold while start=1.
- start=0 in any state, sampled at an edge: go to IDLE, done <= 0, `out` keeps its last value. This includes abandoning an operation mid-round; no partial result is published.
- A new operation requires start to be low for at least one edge, then high again.
- S-box: combinational, 16 instances for the state plus 4 per generated word.

## Timing
- Reset (rst=0, asynchronous): out = 0, done = 0, FSM = IDLE, round = 0, key window cleared.
- Reset release is synchronous to `clk`. The first request is accepted at the first edge after release with start=1.
- Call edge E0 the first edge at which start=1 is sampled in IDLE.
- `done` and `out` update at edge E0+NR: edge 10 (AES-128), 12 (AES-192), 14 (AES-256) after E0. Total latency is NR+1 edges including E0.
- `done` is registered and glitch-free. It stays high until start is sampled low or rst asserts.
- `done` falls at the edge after start falls.
- rst asserted mid-operation aborts immediately; outputs go to their reset values.

## Configuration
- Macro ENCRYPT_ITERATIVE_PARAM_CHECK_EN.
- Defined: an elaboration/time-0 check requires (KEY_WIDTH,NR,NK) to be (128,10,4), (192,12,6) or (256,14,8). Any other combination produces $error naming the instance and ends simulation with $fatal.
- Not defined: no check; illegal combinations give undefined results.
- No effect on synthesised logic.

## Test plan
- AES-128: in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> out=69c4e0d86a7b0430d8cdb78070b4c55a; done rises exactly 10 edges after E0.
- AES-192: same in, key=000102…1617 -> out=dda97ca4864cdfe06eaf70a0ec0d7191; done at E0+12. AES-256: key=000102…1e1f -> out=8ea2b7ca516745bfeafc49904b496089; done at E0+14. All three instances share clk, rst and start.
- AES-128: in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> out=3925841d02dc09fbdc118597196a0b32.
- Drop start at E0+5, then reassert it with new in -> done stays 0 through the abort; new correct result arrives NR edges after the new E0.
- Assert rst at E0+4 -> out=0 and done=0 immediately; after release with start=1, a correct result follows.
- Change in and key after E0 -> result still matches the values sampled at E0.
